// File: rtl/mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// mips_multicycle_ctrl
//
// Multicycle sequencing controller for the MIPS datapath. Each instruction is
// walked through FETCH / DECODE / EXECUTE / MEM / WRITEBACK states. The shared
// unified memory port is driven through a mem_req / mem_ready handshake, and
// the PC, IR, ALU operand muxes and register file write are sequenced from the
// current state.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   opcode, funct       IR[31:26] and IR[5:0] (valid from DECODE onward)
//   zero                ALU zero flag (branch resolution)
//   mem_ready           memory completes the current access this cycle
//   mem_req, mem_we     memory request / write qualifier
//   iord                memory address select: 0=PC, 1=ALUOut
//   ir_write, pc_write  IR load, unconditional PC load
//   pc_src              00=ALU, 01=ALUOut, 10=jump target, 11=rs
//   alu_src_a/b, alu_op ALU operand selects and operation (ula_ctrl encoding)
//   zero_ext            zero-extend the immediate (andi/ori/xori)
//   reg_dst, mem_to_reg register file write address / data selects
//   reg_write           register file write enable
//   halted, trap_cause  HALT indication: 01 illegal opcode, 10 memory timeout
//   state               current state encoding (debug)
//
// Parameters:
//   MEM_WAIT_MAX  stalled cycles tolerated on one access before trapping to
//                 HALT; 0 disables the timeout.
//   CNT_W         width of the performance counters.
//
// Optional build macro MIPS_MCTRL_PERF_EN adds the instr_retired and
// mem_stall_cycles saturating counters as extra outputs.
// -----------------------------------------------------------------------------
module mips_multicycle_ctrl #(
    parameter int unsigned MEM_WAIT_MAX = 255,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [3:0]       alu_op,
    output logic             zero_ext,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic             reg_write,
    output logic             halted,
    output logic [1:0]       trap_cause,
    output logic [3:0]       state
`ifdef MIPS_MCTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] instr_retired,
    output logic [CNT_W-1:0] mem_stall_cycles
`endif
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_MEM_WB   = 4'd7,
        S_WB_R     = 4'd8,
        S_WB_I     = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_JAL      = 4'd12,
        S_JR       = 4'd13,
        S_HALT     = 4'd15
    } state_t;

    // Opcodes of the supported subset.
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    // ALUOp encoding understood by ula_ctrl.
    localparam logic [3:0] ALU_FUNCT = 4'b0000;
    localparam logic [3:0] ALU_ADD   = 4'b1000;
    localparam logic [3:0] ALU_SUB   = 4'b1001;
    localparam logic [3:0] ALU_AND   = 4'b1010;
    localparam logic [3:0] ALU_OR    = 4'b1011;
    localparam logic [3:0] ALU_XOR   = 4'b1100;
    localparam logic [3:0] ALU_SLT   = 4'b1101;
    localparam logic [3:0] ALU_SLTU  = 4'b1110;
    localparam logic [3:0] ALU_LUI   = 4'b1111;

    localparam logic [1:0] TRAP_NONE    = 2'b00;
    localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
    localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

    // Wait counter only has to reach MEM_WAIT_MAX-1; keep at least one bit so
    // the disabled configuration still elaborates.
    localparam int unsigned WCNT_W = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);
    localparam bit          TIMEOUT_EN = (MEM_WAIT_MAX != 0);
    localparam logic [WCNT_W-1:0] WAIT_LAST =
        WCNT_W'((MEM_WAIT_MAX == 0) ? 0 : MEM_WAIT_MAX - 1);

    state_t            cur_state;
    state_t            nxt_state;
    logic [1:0]        trap_nxt;
    logic [WCNT_W-1:0] wait_cnt;
    logic              stall;
    logic              timeout;

    assign state  = cur_state;
    assign halted = (cur_state == S_HALT);
    assign stall  = mem_req && !mem_ready;
    // Fires on the stalled cycle that brings the count to MEM_WAIT_MAX; a
    // mem_ready in that same cycle is not a stall, so it wins.
    assign timeout = TIMEOUT_EN && stall && (wait_cnt == WAIT_LAST);

    // -------------------------------------------------------------------------
    // State, trap cause and wait counter registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state  <= S_FETCH;
            trap_cause <= TRAP_NONE;
            wait_cnt   <= '0;
        end else begin
            cur_state  <= nxt_state;
            trap_cause <= trap_nxt;
            if ((nxt_state != cur_state) &&
                (nxt_state == S_FETCH || nxt_state == S_MEM_RD || nxt_state == S_MEM_WR)) begin
                wait_cnt <= '0;
            end else if (stall && (wait_cnt != '1)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output decode
    // -------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        nxt_state  = cur_state;
        trap_nxt   = trap_cause;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = ALU_ADD;
        zero_ext   = 1'b0;
        reg_dst    = 2'b00;
        mem_to_reg = 2'b00;
        reg_write  = 1'b0;

        case (cur_state)
            S_FETCH: begin
                // PC+4 is computed alongside the instruction read and written
                // back on the cycle the memory delivers the word.
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) begin
                    nxt_state = S_DECODE;
                end else if (timeout) begin
                    nxt_state = S_HALT;
                    trap_nxt  = TRAP_TIMEOUT;
                end
            end

            S_DECODE: begin
                // Branch target is speculatively formed into ALUOut.
                alu_src_b = 2'b11;
                case (opcode)
                    OP_RTYPE: nxt_state = (funct == FN_JR) ? S_JR : S_EXEC_R;
                    OP_LW, OP_SW: nxt_state = S_MEM_ADDR;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_XORI,
                    OP_LUI, OP_SLTI, OP_SLTIU: nxt_state = S_EXEC_I;
                    OP_BEQ, OP_BNE: nxt_state = S_BRANCH;
                    OP_J:   nxt_state = S_JUMP;
                    OP_JAL: nxt_state = S_JAL;
                    default: begin
                        nxt_state = S_HALT;
                        trap_nxt  = TRAP_ILLEGAL;
                    end
                endcase
            end

            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b00;
                alu_op    = ALU_FUNCT;
                nxt_state = S_WB_R;
            end

            S_WB_R: begin
                reg_dst   = 2'b01;
                reg_write = 1'b1;
                nxt_state = S_FETCH;
            end

            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                case (opcode)
                    OP_SLTI:  alu_op = ALU_SLT;
                    OP_SLTIU: alu_op = ALU_SLTU;
                    OP_ANDI: begin alu_op = ALU_AND; zero_ext = 1'b1; end
                    OP_ORI:  begin alu_op = ALU_OR;  zero_ext = 1'b1; end
                    OP_XORI: begin alu_op = ALU_XOR; zero_ext = 1'b1; end
                    OP_LUI:   alu_op = ALU_LUI;
                    default:  alu_op = ALU_ADD;
                endcase
                nxt_state = S_WB_I;
            end

            S_WB_I: begin
                reg_write = 1'b1;
                nxt_state = S_FETCH;
            end

            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                nxt_state = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end

            S_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    nxt_state = S_MEM_WB;
                end else if (timeout) begin
                    nxt_state = S_HALT;
                    trap_nxt  = TRAP_TIMEOUT;
                end
            end

            S_MEM_WB: begin
                mem_to_reg = 2'b01;
                reg_write  = 1'b1;
                nxt_state  = S_FETCH;
            end

            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    nxt_state = S_FETCH;
                end else if (timeout) begin
                    nxt_state = S_HALT;
                    trap_nxt  = TRAP_TIMEOUT;
                end
            end

            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b00;
                alu_op    = ALU_SUB;
                pc_src    = 2'b01;
                pc_write  = (opcode == OP_BEQ) ? zero : !zero;
                nxt_state = S_FETCH;
            end

            S_JUMP: begin
                pc_src    = 2'b10;
                pc_write  = 1'b1;
                nxt_state = S_FETCH;
            end

            S_JAL: begin
                // PC already holds the return address (PC+4) from FETCH.
                pc_src     = 2'b10;
                pc_write   = 1'b1;
                reg_dst    = 2'b10;
                mem_to_reg = 2'b10;
                reg_write  = 1'b1;
                nxt_state  = S_FETCH;
            end

            S_JR: begin
                pc_src    = 2'b11;
                pc_write  = 1'b1;
                nxt_state = S_FETCH;
            end

            S_HALT: begin
                nxt_state = S_HALT;
            end

            default: begin
                // Unused encoding: park safely, only reset leaves.
                nxt_state = S_HALT;
            end
        endcase
    end

`ifdef MIPS_MCTRL_PERF_EN
    // -------------------------------------------------------------------------
    // Saturating performance counters
    // -------------------------------------------------------------------------
    logic retire;

    // HALT never transitions to FETCH, so only completed instructions count.
    assign retire = (nxt_state == S_FETCH) && (cur_state != S_FETCH) && (cur_state != S_HALT);

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_retired    <= '0;
            mem_stall_cycles <= '0;
        end else begin
            if (retire && (instr_retired != '1)) begin
                instr_retired <= instr_retired + 1'b1;
            end
            if (stall && (mem_stall_cycles != '1)) begin
                mem_stall_cycles <= mem_stall_cycles + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mips_multicycle_ctrl
//
// Scoreboard bench for mips_multicycle_ctrl. A plan of instructions (opcode,
// funct, zero, fetch/data wait states) is generated; for each one an
// instruction-level expectation (cycle count, enables seen, selects used) is
// pushed into a queue. A memory responder executes the plan against the DUT
// handshake, and a monitor accumulates the observed behaviour of each
// instruction and compares it when the DUT returns to FETCH. Directed
// sequences then cover reset, illegal opcode, memory timeout and recovery.
// -----------------------------------------------------------------------------
module tb_mips_multicycle_ctrl;

    localparam int unsigned WAIT_MAX = 4;
    localparam int unsigned CNT_W    = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, mem_we, iord, ir_write, pc_write;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic       zero_ext;
    logic [1:0] reg_dst, mem_to_reg;
    logic       reg_write, halted;
    logic [1:0] trap_cause;
    logic [3:0] state;
`ifdef MIPS_MCTRL_PERF_EN
    logic [CNT_W-1:0] instr_retired, mem_stall_cycles;
`endif

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.MEM_WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .iord       (iord),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .zero_ext   (zero_ext),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .halted     (halted),
        .trap_cause (trap_cause),
        .state      (state)
`ifdef MIPS_MCTRL_PERF_EN
        ,
        .instr_retired    (instr_retired),
        .mem_stall_cycles (mem_stall_cycles)
`endif
    );

    // Instruction-level summary of what the controller must do.
    typedef struct packed {
        logic [7:0] cycles;
        logic [3:0] n_irw;
        logic [3:0] n_pcw;
        logic [1:0] pcsrc;     // pc_src on the last PC write
        logic [3:0] n_rw;
        logic [1:0] rdst;      // reg_dst on the register write
        logic [1:0] m2r;       // mem_to_reg on the register write
        logic [3:0] n_rd;      // completed memory reads
        logic [3:0] n_wr;      // completed memory writes
        logic [3:0] n_exec;    // cycles using the A register operand
        logic [3:0] exec_op;   // alu_op in that cycle
        logic       zext;
    } rec_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        int         fw;
        int         dw;
    } plan_t;

    plan_t plan_q[$];
    rec_t  exp_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int done     = 0;
    bit drv_en   = 1'b0;
    bit mon_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------------------------------------------------------- model
    function automatic logic [3:0] imm_alu(input logic [5:0] op);
        case (op)
            6'b001010: return 4'b1101;   // slti
            6'b001011: return 4'b1110;   // sltiu
            6'b001100: return 4'b1010;   // andi
            6'b001101: return 4'b1011;   // ori
            6'b001110: return 4'b1100;   // xori
            6'b001111: return 4'b1111;   // lui
            default:   return 4'b1000;   // addi
        endcase
    endfunction

    function automatic rec_t model(input plan_t p);
        rec_t r = '0;
        int   cyc;
        r.n_irw = 1;
        r.n_pcw = 1;
        r.n_rd  = 1;
        case (p.op)
            6'b000000: begin
                if (p.fn == 6'b001000) begin
                    cyc = 3; r.n_pcw = 2; r.pcsrc = 2'b11;
                end else begin
                    cyc = 4; r.n_rw = 1; r.rdst = 2'b01; r.n_exec = 1; r.exec_op = 4'b0000;
                end
            end
            6'b100011: begin
                cyc = 5 + p.dw; r.n_rd = 2; r.n_rw = 1; r.m2r = 2'b01;
                r.n_exec = 1; r.exec_op = 4'b1000;
            end
            6'b101011: begin
                cyc = 4 + p.dw; r.n_wr = 1; r.n_exec = 1; r.exec_op = 4'b1000;
            end
            6'b000100, 6'b000101: begin
                cyc = 3; r.n_exec = 1; r.exec_op = 4'b1001;
                if ((p.op == 6'b000100) ? p.z : !p.z) begin
                    r.n_pcw = 2; r.pcsrc = 2'b01;
                end
            end
            6'b000010: begin cyc = 3; r.n_pcw = 2; r.pcsrc = 2'b10; end
            6'b000011: begin
                cyc = 3; r.n_pcw = 2; r.pcsrc = 2'b10;
                r.n_rw = 1; r.rdst = 2'b10; r.m2r = 2'b10;
            end
            default: begin   // immediate ALU group
                cyc = 4; r.n_rw = 1; r.n_exec = 1; r.exec_op = imm_alu(p.op);
                r.zext = (p.op == 6'b001100 || p.op == 6'b001101 || p.op == 6'b001110);
            end
        endcase
        r.cycles = 8'(cyc + p.fw);
        return r;
    endfunction

    // ------------------------------------------------------- memory responder
    // Runs 3 time units after each rising edge: reads the plan for every new
    // fetch and answers each access after the planned number of wait states.
    initial begin
        plan_t cur_p;
        bit    have_plan = 1'b0;
        bit    in_access = 1'b0;
        int    wcnt = 0;
        int    target;
        forever begin
            @(posedge clk);
            #3;
            if (drv_en && !reset) begin
                if (mem_req) begin
                    if (!in_access) begin
                        if (!iord) begin
                            if (plan_q.size() > 0) begin
                                cur_p     = plan_q.pop_front();
                                opcode    = cur_p.op;
                                funct     = cur_p.fn;
                                zero      = cur_p.z;
                                have_plan = 1'b1;
                            end else begin
                                have_plan = 1'b0;
                            end
                        end
                        in_access = 1'b1;
                        wcnt      = 0;
                    end
                    target = !have_plan ? 1000 : (!iord ? cur_p.fw : cur_p.dw);
                    if (wcnt < target) begin
                        mem_ready = 1'b0;
                        wcnt++;
                    end else begin
                        mem_ready = 1'b1;
                        in_access = 1'b0;
                    end
                end else begin
                    mem_ready = 1'($urandom_range(0, 1));
                    in_access = 1'b0;
                end
            end
        end
    end

    // ---------------------------------------------------------------- monitor
    initial begin
        rec_t     obs;
        rec_t     exp;
        bit       started = 1'b0;
        logic [3:0] prev_state = 4'd0;
        forever begin
            @(negedge clk);
            if (!mon_en || reset) begin
                started = 1'b0;
            end else begin
                if (state == 4'd0 && (!started || prev_state != 4'd0)) begin
                    if (started) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_instr", 64'(obs), 64'd0);
                        end else begin
                            exp = exp_q.pop_front();
                            check($sformatf("instr%0d_cycles", done), 64'(obs.cycles), 64'(exp.cycles));
                            check($sformatf("instr%0d_summary", done), 64'(obs), 64'(exp));
                        end
                        done++;
                    end
                    started = 1'b1;
                    obs     = '0;
                end
                if (started) begin
                    obs.cycles = obs.cycles + 1'b1;
                    if (ir_write) obs.n_irw = obs.n_irw + 1'b1;
                    if (pc_write) begin
                        obs.n_pcw = obs.n_pcw + 1'b1;
                        obs.pcsrc = pc_src;
                    end
                    if (reg_write) begin
                        obs.n_rw = obs.n_rw + 1'b1;
                        obs.rdst = reg_dst;
                        obs.m2r  = mem_to_reg;
                    end
                    if (mem_req && mem_ready) begin
                        if (mem_we) obs.n_wr = obs.n_wr + 1'b1;
                        else        obs.n_rd = obs.n_rd + 1'b1;
                    end
                    if (alu_src_a) begin
                        obs.n_exec  = obs.n_exec + 1'b1;
                        obs.exec_op = alu_op;
                    end
                    if (zero_ext) obs.zext = 1'b1;
                end
                prev_state = state;
            end
        end
    end

    // --------------------------------------------------------------- stimulus
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Two reset cycles; returns inside the first cycle after release.
    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic add_plan(input logic [5:0] op, input logic [5:0] fn, input logic z,
                            input int fw, input int dw);
        plan_t p;
        p.op = op; p.fn = fn; p.z = z; p.fw = fw; p.dw = dw;
        plan_q.push_back(p);
        exp_q.push_back(model(p));
    endtask

    localparam int N_RAND = 48;

    initial begin
        logic [5:0] kinds [16];
        int         n_total;
        int         stall_sum = 0;
        bit         finished = 1'b0;

        kinds = '{6'b000000, 6'b000000, 6'b100011, 6'b101011, 6'b001000, 6'b001010,
                  6'b001011, 6'b001100, 6'b001101, 6'b001110, 6'b001111, 6'b000100,
                  6'b000101, 6'b000010, 6'b000011, 6'b000000};

        reset     = 1'b1;
        mem_ready = 1'b1;
        opcode    = 6'b000000;
        funct     = 6'b100000;
        zero      = 1'b0;

        // Reset state and first FETCH cycle with zero-wait memory.
        tick();
        @(negedge clk);
        check("reset_state", 64'(state), 64'd0);
        check("reset_trap", 64'(trap_cause), 64'd0);
        do_reset();
        @(negedge clk);
        check("rel_state", 64'(state), 64'd0);
        check("rel_fetch_enables", 64'({mem_req, ir_write, pc_write, iord, halted}), 64'b11100);

        // Scoreboard phase: directed prefix followed by random instructions.
        reset = 1'b1;
        tick();
        add_plan(6'b000000, 6'b100000, 1'b0, 0, 0);   // add
        add_plan(6'b100011, 6'b000000, 1'b0, 0, 3);   // lw, 3 data wait states
        add_plan(6'b000100, 6'b000000, 1'b1, 0, 0);   // beq taken
        add_plan(6'b000101, 6'b000000, 1'b1, 0, 0);   // bne not taken
        add_plan(6'b000011, 6'b000000, 1'b0, 0, 0);   // jal
        add_plan(6'b000000, 6'b001000, 1'b0, 0, 0);   // jr
        add_plan(6'b101011, 6'b000000, 1'b0, 3, 3);   // sw, waits at the timeout edge
        add_plan(6'b001101, 6'b000000, 1'b0, 1, 0);   // ori
        for (int i = 0; i < N_RAND; i++) begin
            logic [5:0] op;
            logic [5:0] fn;
            op = kinds[$urandom_range(0, 15)];
            fn = 6'($urandom_range(0, 63));
            add_plan(op, fn, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
        end
        n_total = plan_q.size();
        foreach (plan_q[i]) begin
            stall_sum += plan_q[i].fw;
            if (plan_q[i].op == 6'b100011 || plan_q[i].op == 6'b101011) stall_sum += plan_q[i].dw;
        end
        drv_en = 1'b1;
        mon_en = 1'b1;
        tick();
        reset = 1'b0;

        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            #1;
            if (done == n_total) begin
                finished = 1'b1;
                break;
            end
        end
        check("all_instr_retired", 64'(finished), 64'd1);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
`ifdef MIPS_MCTRL_PERF_EN
        check("perf_instr_retired", 64'(instr_retired), 64'(n_total));
        check("perf_mem_stalls", 64'(mem_stall_cycles), 64'(stall_sum));
`endif
        mon_en = 1'b0;
        drv_en = 1'b0;
        tick();

        // Illegal opcode traps to HALT and stays there.
        opcode    = 6'b111111;
        mem_ready = 1'b1;
        do_reset();
        tick();
        tick();
        @(negedge clk);
        check("illegal_state", 64'(state), 64'd15);
        check("illegal_trap", 64'({halted, trap_cause}), 64'b101);
        check("halt_enables_off", 64'({mem_req, pc_write, ir_write, reg_write}), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            mem_ready = ~mem_ready;
        end
        @(negedge clk);
        check("halt_sticky", 64'({state, trap_cause}), 64'({4'd15, 2'b01}));

        // Reset recovers from HALT.
        do_reset();
        @(negedge clk);
        check("recover_illegal", 64'({state, halted, trap_cause}), 64'({4'd0, 1'b0, 2'b00}));

        // Memory timeout: four stalled FETCH cycles, then HALT with cause 10.
        mem_ready = 1'b0;
        do_reset();
        tick();
        tick();
        tick();
        @(negedge clk);
        check("timeout_last_wait", 64'({state, trap_cause}), 64'({4'd0, 2'b00}));
        tick();
        @(negedge clk);
        check("timeout_state", 64'({state, halted, trap_cause}), 64'({4'd15, 1'b1, 2'b10}));
        check("timeout_req_dropped", 64'(mem_req), 64'd0);

        // Reset in the middle of a stall restarts the wait count.
        do_reset();
        tick();
        do_reset();
        tick();
        tick();
        tick();
        @(negedge clk);
        check("midwait_reset_count", 64'({state, trap_cause}), 64'({4'd0, 2'b00}));
        tick();
        @(negedge clk);
        check("midwait_timeout", 64'({state, trap_cause}), 64'({4'd15, 2'b10}));

        mem_ready = 1'b1;
        opcode    = 6'b000000;
        do_reset();
        @(negedge clk);
        check("recover_timeout", 64'({state, halted, trap_cause, mem_req}),
              64'({4'd0, 1'b0, 2'b00, 1'b1}));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Multicycle sequencing controller for the MIPS datapath. It replaces the single-cycle decoder and spreads each instruction over FETCH/DECODE/EXECUTE/MEM/WRITEBACK states. It drives the shared unified memory port through a req/ready handshake and sequences the PC, IR, ALU operand muxes and register file write. The ISA subset and ALUOp encoding are those the existing ula_ctrl accepts.

Parameters:
MEM_WAIT_MAX, 255, max cycles waiting on mem_ready before trapping to HALT; 0 disables the timeout.
CNT_W, 32, width of performance counters (used only with the optional feature).

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
opcode  in  6  IR[31:26], valid from DECODE onward.
funct  in  6  IR[5:0].
zero  in  1  ALU zero flag.
mem_ready  in  1  memory completes the current access this cycle.
mem_req  out  1  memory access request.
mem_we  out  1  1=write, qualified by mem_req.
iord  out  1  address mux: 0=PC, 1=ALUOut.
ir_write  out  1  load IR from memory read data.
pc_write  out  1  unconditional PC load.
pc_src  out  2  00=ALU result, 01=ALUOut (branch target), 10=jump target {PC[31:28],addr,00}, 11=rs (jr).
alu_src_a  out  1  0=PC, 1=A register.
alu_src_b  out  2  00=B, 01=const 4, 10=ext imm, 11=sext imm<<2.
alu_op  out  4  0000 R (use funct), 1000 add, 1001 sub, 1010 and, 1011 or, 1100 xor, 1101 slt, 1110 sltu, 1111 lui.
zero_ext  out  1  zero-extend imm (andi/ori/xori).
reg_dst  out  2  00=rt, 01=rd, 10=$31.
mem_to_reg  out  2  00=ALUOut, 01=MDR, 10=PC (link).
reg_write  out  1  register file write enable.
halted  out  1  controller in HALT.
trap_cause  out  2  00 none, 01 illegal opcode, 10 memory timeout.
state  out  4  current state encoding, for debug.

Behaviour:
- States: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, MEM_ADDR=4, MEM_RD=5, MEM_WR=6, MEM_WB=7, WB_R=8, WB_I=9, BRANCH=10, JUMP=11, JAL=12, JR=13, HALT=15.
- Outputs are Moore decodes of state, except the mem_ready-gated signals below. Defaults: all 0 (alu_op=1000).
- reset: state<=FETCH, wait counter<=0, trap_cause<=00. Reset overrides all, including HALT and mid-wait.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, add. ir_write=pc_write=mem_ready (pc_src=00). Stay until mem_ready, then go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, add (branch target into ALUOut). Next state:
  - R, funct!=001000 -> EXEC_R; funct 001000 -> JR.
  - lw/sw -> MEM_ADDR.
  - addi/andi/ori/xori/lui/slti/sltiu -> EXEC_I.
  - beq/bne -> BRANCH.
  - j -> JUMP; jal -> JAL.
  - any other opcode -> HALT, cause 01.
- EXEC_R: a=1, b=00, alu_op=0000 -> WB_R. WB_R: reg_dst=01, mem_to_reg=00, reg_write=1 -> FETCH.
- EXEC_I: a=1, b=10, alu_op per opcode, zero_ext=1 for andi/ori/xori -> WB_I. WB_I: reg_dst=00, reg_write=1 -> FETCH.
- MEM_ADDR: a=1, b=10, add -> MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: mem_req=1, iord=1; on mem_ready -> MEM_WB. MEM_WB: mem_to_reg=01, reg_dst=00, reg_write=1 -> FETCH.
- MEM_WR: mem_req=1, mem_we=1, iord=1; on mem_ready -> FETCH.
- BRANCH: a=1, b=00, sub, pc_src=01. pc_write = zero (beq) or !zero (bne). -> FETCH.
- JUMP: pc_src=10, pc_write=1 -> FETCH. JAL: same, plus reg_dst=10, mem_to_reg=10, reg_write=1 (PC already +4). JR: pc_src=11, pc_write=1, no reg_write -> FETCH.
- Latency at zero-wait memory: R/I 4, lw 5, sw 4, beq/bne/j/jal/jr 3 cycles.
- Wait counter: clears on entry to FETCH/MEM_RD/MEM_WR and increments each cycle mem_req=1 && !mem_ready. When MEM_WAIT_MAX!=0 and the counter reaches MEM_WAIT_MAX without mem_ready: go to HALT, cause 10, mem_req drops next cycle. If mem_ready arrives in the same cycle as the limit, mem_ready wins.
- HALT: all enables 0, halted=1; leave only via reset.

Optional Feature:
MIPS_MCTRL_PERF_EN: adds outputs instr_retired[CNT_W-1:0] and mem_stall_cycles[CNT_W-1:0].
- instr_retired increments on each transition into FETCH from a non-reset, non-HALT state.
- mem_stall_cycles increments each cycle mem_req=1 && !mem_ready.
- Both clear on reset and saturate at all-ones.
- Without the macro the ports are absent and behaviour is otherwise identical.

Test Plan:
- reset=1 for 2 cycles, mem_ready=1 -> state=0, mem_req=1, ir_write=1, pc_write=1 on the first cycle after release.
- add (opcode 000000, funct 100000), mem_ready=1 -> states 0,1,2,8; reg_write=1 and reg_dst=01 in cycle 4 only.
- lw with mem_ready low 3 cycles in MEM_RD -> stays in state 5 for 4 cycles, iord=1 throughout, then 7 with mem_to_reg=01; 8 cycles total.
- beq with zero=1 -> pc_write=1, pc_src=01 in BRANCH; bne with zero=1 -> pc_write=0.
- opcode 111111 -> HALT, halted=1, trap_cause=01; MEM_WAIT_MAX=4 with mem_ready held 0 in FETCH -> HALT after 4 cycles, trap_cause=10; reset recovers to FETCH.
- jal -> reg_dst=10, mem_to_reg=10, reg_write=1, pc_src=10; jr (funct 001000) -> pc_src=11, reg_write=0; with MIPS_MCTRL_PERF_EN, instr_retired=2 after both.
